// File: rtl/multi_dataflow_mmult_opt_mdc_launcher.sv
// multi_dataflow_mmult_opt_mdc_launcher: HWPE periph-port job launcher (acquire, program, trigger, wait); readback checking via MMULT_OPT_MDC_LAUNCH_READBACK_EN
module multi_dataflow_mmult_opt_mdc_launcher #(
   parameter int unsigned          N_PARAMS     = 8,
   parameter int unsigned          ID_WIDTH     = 10,
   parameter logic [31:0]          BASE_ADDR    = 32'h0,
   parameter logic [31:0]          JOB_OFFSET   = 32'h40,
   parameter int unsigned          RETRY_CYCLES = 4,
   parameter logic [ID_WIDTH-1:0]  MY_ID        = '0
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      start_i,
   input  logic [N_PARAMS-1:0][31:0] params_i,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      error_o,
   input  logic                      evt_i,
   output logic                      periph_req_o,
   input  logic                      periph_gnt_i,
   output logic [31:0]               periph_add_o,
   output logic                      periph_wen_o,
   output logic [3:0]                periph_be_o,
   output logic [31:0]               periph_data_o,
   output logic [ID_WIDTH-1:0]       periph_id_o,
   input  logic                      periph_r_valid_i,
   input  logic [31:0]               periph_r_data_i,
   input  logic [ID_WIDTH-1:0]       periph_r_id_i
);
   localparam int unsigned IW = N_PARAMS > 1 ? $clog2(N_PARAMS) : 1;
   localparam int unsigned CW = $clog2(RETRY_CYCLES + 1);
   typedef enum logic [3:0] {
      IDLE, ACQ_REQ, ACQ_RSP, BACKOFF, WR, TRIG, WAIT_EVT, DONE
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
      , RB_REQ, RB_RSP
`endif
   } state_e;
   state_e                    state_q, state_d;
   logic [IW-1:0]             idx_q, idx_d;
   logic [CW-1:0]             cnt_q, cnt_d;
   logic [N_PARAMS-1:0][31:0] param_q, param_d;
   logic                      busy_q, busy_d, done_q, done_d, req_q, req_d, wen_q, wen_d;
   logic [31:0]               add_q, add_d, data_q, data_d, job_add;
   logic                      rsp_ok, last_idx;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
   logic                      error_q, error_d;
   assign error_o = error_q;
`else
   logic                      unused_rdata;
   assign unused_rdata = ^periph_r_data_i[30:0];
   assign error_o      = 1'b0;
`endif
   assign rsp_ok        = periph_r_valid_i && (periph_r_id_i == MY_ID);
   assign last_idx      = idx_q == IW'(N_PARAMS - 1);
   assign periph_be_o   = 4'hF;
   assign periph_id_o   = MY_ID;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign periph_req_o  = req_q;
   assign periph_add_o  = add_q;
   assign periph_wen_o  = wen_q;
   assign periph_data_o = data_q;
   // launch sequencing: one transaction in flight, retries after a busy acquire
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      param_d = param_q;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
      error_d = error_q;
`endif
      case (state_q)
         IDLE: if (start_i) begin
            state_d = ACQ_REQ;
            idx_d   = '0;
            param_d = params_i;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
            error_d = 1'b0;
`endif
         end
         ACQ_REQ: state_d = periph_gnt_i ? ACQ_RSP : ACQ_REQ;
         ACQ_RSP: if (rsp_ok) begin
            state_d = periph_r_data_i[31] ? BACKOFF : WR;
            cnt_d   = '0;
         end
         BACKOFF: begin
            cnt_d   = cnt_q + 1'b1;
            state_d = cnt_q == CW'(RETRY_CYCLES - 1) ? ACQ_REQ : BACKOFF;
         end
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
         WR:     state_d = periph_gnt_i ? RB_REQ : WR;
         RB_REQ: state_d = periph_gnt_i ? RB_RSP : RB_REQ;
         RB_RSP: if (rsp_ok) begin
            error_d = error_q | (periph_r_data_i != param_q[idx_q]);
            state_d = last_idx ? TRIG : WR;
            idx_d   = last_idx ? idx_q : idx_q + 1'b1;
         end
`else
         WR: if (periph_gnt_i) begin
            state_d = last_idx ? TRIG : WR;
            idx_d   = last_idx ? idx_q : idx_q + 1'b1;
         end
`endif
         TRIG:     state_d = periph_gnt_i ? WAIT_EVT : TRIG;
         WAIT_EVT: state_d = evt_i ? DONE : WAIT_EVT;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end
   // registered bus and status outputs derived from the next state
   always_comb begin
      job_add = BASE_ADDR + JOB_OFFSET + (32'(idx_d) << 2);
      busy_d  = state_d != IDLE;
      done_d  = state_d == DONE;
      req_d   = state_d == ACQ_REQ || state_d == WR || state_d == TRIG;
      wen_d   = !(state_d == WR || state_d == TRIG);
      data_d  = state_d == WR ? param_q[idx_d] : '0;
      add_d   = state_d == WR ? job_add : state_d == ACQ_REQ ? BASE_ADDR + 32'h4 : state_d == TRIG ? BASE_ADDR : '0;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
      req_d   = req_d || state_d == RB_REQ;
      add_d   = state_d == RB_REQ ? job_add : add_d;
`endif
   end
   // state and output registers, cleared asynchronously
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         param_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         req_q   <= 1'b0;
         wen_q   <= 1'b1;
         add_q   <= '0;
         data_q  <= '0;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         param_q <= param_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         req_q   <= req_d;
         wen_q   <= wen_d;
         add_q   <= add_d;
         data_q  <= data_d;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
         error_q <= error_d;
`endif
      end
   end
endmodule

// File: tb/tb_multi_dataflow_mmult_opt_mdc_launcher.sv
// tb_multi_dataflow_mmult_opt_mdc_launcher: scoreboard bench for the mmult_opt_mdc job launcher
module tb_multi_dataflow_mmult_opt_mdc_launcher;
   localparam int N = 8;
`ifdef MMULT_OPT_MDC_LAUNCH_READBACK_EN
   localparam bit RB = 1'b1;
`else
   localparam bit RB = 1'b0;
`endif
   localparam int TRIG_C = 3 + (RB ? 3 : 1) * N;

   logic clk, rst_ni, start_i, evt_i, busy_o, done_o, error_o;
   logic [N-1:0][31:0] params_i, prm;
   logic periph_req_o, periph_gnt_i, periph_wen_o, periph_r_valid_i;
   logic [31:0] periph_add_o, periph_data_o, periph_r_data_i;
   logic [3:0] periph_be_o;
   logic [9:0] periph_id_o;

   typedef struct { logic [31:0] a; logic w; logic [31:0] d; } txn_t;
   txn_t exp_q[$];
   txn_t mon_e;
   int done_q[$];
   int acq_log[$];
   logic [31:0] acq_q[$];
   logic [31:0] mem [N];
   logic [31:0] stall_add, sa;
   int cyc = 0, t0 = 0, trig_cyc = 0, trig_cnt = 0, trig0 = 0, done_cnt = 0, done0 = 0;
   int hold_cnt = 0, stall_cnt = 0, corrupt = -1, pass_cnt = 0, total_cnt = 0;

   multi_dataflow_mmult_opt_mdc_launcher dut (
      .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .params_i(params_i),
      .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .evt_i(evt_i),
      .periph_req_o(periph_req_o), .periph_gnt_i(periph_gnt_i), .periph_add_o(periph_add_o),
      .periph_wen_o(periph_wen_o), .periph_be_o(periph_be_o), .periph_data_o(periph_data_o),
      .periph_id_o(periph_id_o), .periph_r_valid_i(periph_r_valid_i),
      .periph_r_data_i(periph_r_data_i), .periph_r_id_i(10'd0)
   );

   initial begin clk = 0; forever #5 clk = ~clk; end
   initial forever begin @(posedge clk); cyc++; end
   initial begin #500000; $display("FAIL watchdog: got timeout, want $finish"); $fatal(1); end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic push(input logic [31:0] a, input logic w, input logic [31:0] d);
      txn_t t;
      t.a = a; t.w = w; t.d = d;
      exp_q.push_back(t);
   endtask

   task automatic expect_launch(input int fails);
      for (int i = 0; i <= fails; i++) push(32'h4, 1'b1, 32'h0);
      for (int i = 0; i < N; i++) begin
         push(32'(32'h40 + 4 * i), 1'b0, prm[i]);
         if (RB) push(32'(32'h40 + 4 * i), 1'b1, 32'h0);
      end
      push(32'h0, 1'b0, 32'h0);
   endtask

   task automatic go();
      acq_log.delete();
      @(posedge clk); #1;
      params_i = prm; start_i = 1'b1; t0 = cyc; trig0 = trig_cnt; done0 = done_cnt;
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic wait_trig();
      int g = 0;
      while (trig_cnt == trig0 && g < 2000) begin @(posedge clk); #1; g++; end
      if (trig_cnt == trig0) begin total_cnt++; $display("FAIL trig_timeout: got no trigger, want trigger write"); end
   endtask

   task automatic evt_pulse();
      done_q.push_back(cyc + 1);
      evt_i = 1'b1;
      @(posedge clk); #1;
      evt_i = 1'b0;
   endtask

   task automatic wait_done();
      int g = 0;
      while (done_cnt == done0 && g < 500) begin @(negedge clk); g++; end
      if (done_cnt == done0) begin total_cnt++; $display("FAIL done_timeout: got no done_o, want pulse"); end
      @(negedge clk);
      chk("busy_after_done", busy_o, 0);
      chk("exp_drained", exp_q.size(), 0);
   endtask

   task automatic finish_job(input bit poke);
      @(posedge clk); #1;
      if (poke) begin start_i = 1'b1; @(posedge clk); #1; start_i = 1'b0; end
      evt_pulse();
      wait_done();
   endtask

   // monitor: pops one expected transaction per grant, checks done timing
   initial forever begin
      @(negedge clk);
      if (rst_ni && periph_req_o && periph_gnt_i) begin
         if (periph_wen_o && periph_add_o == 32'h4) acq_log.push_back(cyc);
         if (!periph_wen_o && periph_add_o == 32'h0) begin trig_cyc = cyc; trig_cnt++; end
         if (!periph_wen_o && periph_add_o >= 32'h40 && periph_add_o < 32'h60) mem[int'((periph_add_o - 32'h40) >> 2)] = periph_data_o;
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL txn_extra: got add %h wen %b, want no transaction", periph_add_o, periph_wen_o);
         end else begin
            mon_e = exp_q.pop_front();
            chk("txn_add", periph_add_o, mon_e.a);
            chk("txn_wen", periph_wen_o, mon_e.w);
            if (!mon_e.w) chk("txn_data", periph_data_o, mon_e.d);
         end
      end
      if (periph_req_o && !periph_wen_o && periph_add_o == 32'h4C && periph_data_o == 32'h33) hold_cnt++;
      if (done_o) begin
         done_cnt++;
         if (done_q.size() == 0) begin total_cnt++; $display("FAIL done_extra: got done_o, want none (cycle %0d)", cyc); end
         else chk("done_cycle", cyc, done_q.pop_front());
      end
   end

   // slave read responder: r_valid one cycle after grant
   initial begin
      periph_r_valid_i = 1'b0; periph_r_data_i = '0;
      forever begin
         @(negedge clk);
         if (rst_ni && periph_req_o && periph_gnt_i && periph_wen_o) begin
            sa = periph_add_o;
            @(posedge clk); #1;
            periph_r_valid_i = 1'b1;
            if (sa == 32'h4) periph_r_data_i = acq_q.size() > 0 ? acq_q.pop_front() : 32'h0;
            else begin
               int k;
               k = int'((sa - 32'h40) >> 2);
               periph_r_data_i = mem[k] ^ (k == corrupt ? 32'h1 : 32'h0);
            end
            @(posedge clk); #1;
            periph_r_valid_i = 1'b0;
         end
      end
   end

   // grant driver: optional stall on one write address
   initial begin
      periph_gnt_i = 1'b1;
      forever begin
         @(posedge clk); #1;
         if (stall_cnt > 0 && periph_req_o && !periph_wen_o && periph_add_o == stall_add) begin
            periph_gnt_i = 1'b0; stall_cnt--;
         end else periph_gnt_i = 1'b1;
      end
   end

   initial begin
      int g;
      bit found;
      rst_ni = 1'b0; start_i = 1'b0; evt_i = 1'b0; params_i = '0; prm = '0; stall_add = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_error", error_o, 0);
      chk("rst_req", periph_req_o, 0);
      chk("rst_add", periph_add_o, 0);
      chk("rst_wen", periph_wen_o, 1);
      chk("rst_data", periph_data_o, 0);
      chk("be_const", periph_be_o, 4'hF);
      chk("id_const", periph_id_o, 0);
      @(posedge clk); #3 rst_ni = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_req", periph_req_o, 0);

      // basic launch, exact cycle timing
      for (int i = 0; i < N; i++) prm[i] = 32'(i * 32'h11);
      expect_launch(0);
      go();
      @(negedge clk);
      chk("busy_cycle1", busy_o, 1);
      chk("req_cycle1", periph_req_o, 1);
      @(posedge clk); #1;
      while (cyc - t0 < TRIG_C + 9) begin @(posedge clk); #1; end
      evt_pulse();
      wait_done();
      chk("acq_cycle", acq_log.size() > 0 ? acq_log[0] - t0 : -1, 1);
      chk("trig_cycle", trig_cyc - t0, TRIG_C);

      // busy acquire twice, then free
      for (int i = 0; i < N; i++) prm[i] = 32'(32'hA000_0000 + i);
      acq_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1};
      expect_launch(2);
      go();
      wait_trig();
      finish_job(0);
      chk("acq_count", acq_log.size(), 3);
      if (acq_log.size() == 3) begin
         chk("acq_gap1", acq_log[1] - acq_log[0], 6);
         chk("acq_gap2", acq_log[2] - acq_log[1], 6);
      end

      // grant held low on write 3
      for (int i = 0; i < N; i++) prm[i] = 32'(i * 32'h11);
      stall_add = 32'h4C; stall_cnt = 5; hold_cnt = 0;
      expect_launch(0);
      go();
      wait_trig();
      finish_job(0);
      chk("stall_hold_cycles", hold_cnt, 6);

      // readback mismatch on param 2 (error stays 0 without readback)
      for (int i = 0; i < N; i++) prm[i] = 32'(32'h1234_0000 + i);
      corrupt = 2;
      expect_launch(0);
      go();
      wait_trig();
      @(negedge clk);
      chk("error_mid", error_o, RB);
      finish_job(0);
      chk("error_sticky", error_o, RB);
      corrupt = -1;
      expect_launch(0);
      go();
      @(negedge clk);
      chk("error_cleared", error_o, 0);
      wait_trig();
      finish_job(0);

      // reset during WR with a pending request
      for (int i = 0; i < N; i++) prm[i] = 32'(i * 32'h11);
      stall_add = 32'h50; stall_cnt = 1000;
      expect_launch(0);
      go();
      g = 0; found = 0;
      while (!found && g < 200) begin
         @(negedge clk); g++;
         found = periph_req_o && !periph_wen_o && periph_add_o == 32'h50;
      end
      if (!found) begin total_cnt++; $display("FAIL rst_wait: got no write to 50, want one"); end
      rst_ni = 1'b0;
      #1;
      chk("midrst_req", periph_req_o, 0);
      chk("midrst_busy", busy_o, 0);
      chk("midrst_wen", periph_wen_o, 1);
      chk("midrst_add", periph_add_o, 0);
      exp_q.delete();
      stall_cnt = 0;
      repeat (2) @(posedge clk);
      #3 rst_ni = 1'b1;
      for (int i = 0; i < N; i++) prm[i] = 32'(32'h5500 + i);
      expect_launch(0);
      go();
      wait_trig();
      finish_job(0);

      // evt during WR and start during WAIT_EVT are ignored
      for (int i = 0; i < N; i++) prm[i] = 32'(32'h6600 + i);
      expect_launch(0);
      go();
      while (cyc - t0 < 5) begin @(posedge clk); #1; end
      evt_i = 1'b1;
      @(posedge clk); #1;
      evt_i = 1'b0;
      wait_trig();
      finish_job(1);
      repeat (30) @(negedge clk);
      chk("quiet_busy", busy_o, 0);
      chk("quiet_req", periph_req_o, 0);
      chk("quiet_exp", exp_q.size(), 0);
      chk("quiet_done", done_q.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
